// File: rtl/nubus_master.sv
// NuBus master controller: turns one local single-beat read/write request
// into one arbitrated NuBus address/data transaction and reports the result.
module nubus_master #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        nub_clkn,
  input  logic        reset,
  // card-local request port
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  mem_status,
  // external arbiter
  input  logic        arb_grant,
  // sampled bus (active-low)
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  // pad drivers
  output logic        rqstn_o,
  output logic        startn_o,
  output logic        tm1n_o,
  output logic        tm0n_o,
  output logic [31:0] adn_o,
  output logic        ad_oe,
  output logic        ctl_oe,
  output logic        mstdn_o
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned RTY_W = 2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERROR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  state_e             state_q, state_d;

  // latched request
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [1:0]         a10_q, a10_d;
  logic               byte_q, byte_d;
  logic               bad_q, bad_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;

  // registered outputs
  logic               rqstn_q, rqstn_d;
  logic               startn_q, startn_d;
  logic               tm1n_q, tm1n_d;
  logic               tm0n_q, tm0n_d;
  logic [31:0]        adn_q, adn_d;
  logic               ad_oe_q, ad_oe_d;
  logic               ctl_oe_q, ctl_oe_d;
  logic               mem_ready_q, mem_ready_d;
  logic               mstdn_q, mstdn_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         status_q, status_d;

  // size decode of the incoming request
  logic [1:0]         req_a10_c;
  logic               req_byte_c;
  logic               req_bad_c;
  logic [1:0]         ack_st_c;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[1:0];
  assign ack_st_c        = {~nub_tm1n, ~nub_tm0n};

  // Decode write strobes into NuBus size/lane encoding; reads are always words.
  always_comb begin
    req_a10_c  = 2'b00;
    req_byte_c = 1'b0;
    req_bad_c  = 1'b0;
    if (mem_write) begin
      case (mem_wstrb)
        4'b1111: req_a10_c = 2'b00;
        4'b0011: req_a10_c = 2'b01;
        4'b1100: req_a10_c = 2'b11;
        4'b0001: begin req_byte_c = 1'b1; req_a10_c = 2'b00; end
        4'b0010: begin req_byte_c = 1'b1; req_a10_c = 2'b01; end
        4'b0100: begin req_byte_c = 1'b1; req_a10_c = 2'b10; end
        4'b1000: begin req_byte_c = 1'b1; req_a10_c = 2'b11; end
        default: req_bad_c = 1'b1;
      endcase
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    a10_d       = a10_q;
    byte_d      = byte_q;
    bad_d       = bad_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    rdata_d     = rdata_q;
    status_d    = status_q;

    rqstn_d     = 1'b1;
    startn_d    = 1'b1;
    tm1n_d      = 1'b1;
    tm0n_d      = 1'b1;
    adn_d       = '1;
    ad_oe_d     = 1'b0;
    ctl_oe_d    = 1'b0;
    mem_ready_d = 1'b0;
    mstdn_d     = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr[31:2];
          wdata_d = mem_wdata;
          write_d = mem_write;
          a10_d   = req_a10_c;
          byte_d  = req_byte_c;
          bad_d   = req_bad_c;
          retry_d = '0;
          cnt_d   = '0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        // illegal strobe: finish without ever requesting the bus
        if (bad_q) begin
          status_d = ST_ERROR;
          state_d  = S_DONE;
        end else if (arb_grant && nub_startn && nub_ackn) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        // ACK takes priority over the timeout terminal count
        if (!nub_ackn) begin
          if (!write_q) begin
            rdata_d = ~nub_adn;
          end
          if ((ack_st_c == ST_RETRY) && (retry_q < RTY_W'(MAX_RETRY))) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_ARB;
          end else begin
            status_d = ack_st_c;
            state_d  = S_DONE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d    = cnt_q + CNT_W'(1);
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // bus/local outputs follow the state being entered so they line up with it
    case (state_d)
      S_ARB: begin
        rqstn_d = bad_d;
      end
      S_ADDR: begin
        startn_d = 1'b0;
        ctl_oe_d = 1'b1;
        ad_oe_d  = 1'b1;
        adn_d    = ~{addr_d, a10_d};
        tm1n_d   = ~write_d;
        tm0n_d   = ~byte_d;
      end
      S_DATA: begin
        if (write_d) begin
          ad_oe_d = 1'b1;
          adn_d   = ~wdata_d;
        end
      end
      S_DONE: begin
        mem_ready_d = 1'b1;
        mstdn_d     = 1'b0;
      end
      default: begin
        rqstn_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge nub_clkn or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      a10_q       <= 2'b00;
      byte_q      <= 1'b0;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      retry_q     <= '0;
      rqstn_q     <= 1'b1;
      startn_q    <= 1'b1;
      tm1n_q      <= 1'b1;
      tm0n_q      <= 1'b1;
      adn_q       <= '1;
      ad_oe_q     <= 1'b0;
      ctl_oe_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mstdn_q     <= 1'b1;
      rdata_q     <= '0;
      status_q    <= ST_OK;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      a10_q       <= a10_d;
      byte_q      <= byte_d;
      bad_q       <= bad_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      rqstn_q     <= rqstn_d;
      startn_q    <= startn_d;
      tm1n_q      <= tm1n_d;
      tm0n_q      <= tm0n_d;
      adn_q       <= adn_d;
      ad_oe_q     <= ad_oe_d;
      ctl_oe_q    <= ctl_oe_d;
      mem_ready_q <= mem_ready_d;
      mstdn_q     <= mstdn_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
    end
  end

  assign rqstn_o    = rqstn_q;
  assign startn_o   = startn_q;
  assign tm1n_o     = tm1n_q;
  assign tm0n_o     = tm0n_q;
  assign adn_o      = adn_q;
  assign ad_oe      = ad_oe_q;
  assign ctl_oe     = ctl_oe_q;
  assign mem_ready  = mem_ready_q;
  assign mstdn_o    = mstdn_q;
  assign mem_rdata  = rdata_q;
  assign mem_status = status_q;

endmodule

// File: tb/tb_nubus_master.sv
// Bench for nubus_master: bus slave model, completion scoreboard, directed requests.
module tb_nubus_master;

  logic        nub_clkn;
  logic        reset;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_status;
  logic        arb_grant;
  logic        nub_startn;
  logic        nub_ackn;
  logic        nub_tm1n;
  logic        nub_tm0n;
  logic [31:0] nub_adn;
  logic        rqstn_o;
  logic        startn_o;
  logic        tm1n_o;
  logic        tm0n_o;
  logic [31:0] adn_o;
  logic        ad_oe;
  logic        ctl_oe;
  logic        mstdn_o;

  nubus_master dut (
    .nub_clkn   (nub_clkn),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_status (mem_status),
    .arb_grant  (arb_grant),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .nub_tm1n   (nub_tm1n),
    .nub_tm0n   (nub_tm0n),
    .nub_adn    (nub_adn),
    .rqstn_o    (rqstn_o),
    .startn_o   (startn_o),
    .tm1n_o     (tm1n_o),
    .tm0n_o     (tm0n_o),
    .adn_o      (adn_o),
    .ad_oe      (ad_oe),
    .ctl_oe     (ctl_oe),
    .mstdn_o    (mstdn_o)
  );

  initial nub_clkn = 1'b0;
  always #5 nub_clkn = ~nub_clkn;

  int n_cmp = 0;
  int n_err = 0;

  // expected completions: {status, rdata}
  logic [33:0] exp_q[$];
  logic [31:0] model_rdata = 32'h0;

  // slave configuration
  int          ack_delay = 0;
  int          ta_left   = 0;
  logic [1:0]  ack_st    = 2'b00;
  logic [31:0] rd_val    = 32'h0;

  // slave captures
  logic [31:0] cap_addr;
  logic        cap_tm1n, cap_tm0n, cap_ctl, cap_adoe;
  logic [31:0] cap_data;
  logic        cap_data_oe, cap_data_ctl;

  int rq_falls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave: watches the address phase, answers on a chosen data clock.
  initial begin : slave
    int dcnt;
    bit act;
    act  = 1'b0;
    dcnt = 0;
    nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1; nub_adn = '1;
    forever begin
      @(negedge nub_clkn);
      nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1; nub_adn = '1;
      if (reset) begin
        act = 1'b0;
      end else if (startn_o == 1'b0) begin
        act = 1'b1;
        dcnt = 0;
        cap_addr = adn_o; cap_tm1n = tm1n_o; cap_tm0n = tm0n_o;
        cap_ctl = ctl_oe; cap_adoe = ad_oe;
      end else if (act) begin
        if (dcnt == 0) begin
          cap_data = adn_o; cap_data_oe = ad_oe; cap_data_ctl = ctl_oe;
        end
        if (dcnt == ack_delay) begin
          act = 1'b0;
          nub_ackn = 1'b0;
          if (ta_left > 0) begin
            ta_left--;
            {nub_tm1n, nub_tm0n} = 2'b00;
          end else begin
            {nub_tm1n, nub_tm0n} = ~ack_st;
          end
          nub_adn = ~rd_val;
        end
        dcnt++;
      end
    end
  end

  // Scoreboard / monitor: compares every completion and counts bus requests.
  initial begin : mon
    logic rq_prev;
    logic [33:0] e;
    rq_prev = 1'b1;
    forever begin
      @(negedge nub_clkn);
      if (rq_prev && !rqstn_o) rq_falls++;
      rq_prev = rqstn_o;
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ready", 32'(mem_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("status", 32'(mem_status), 32'(e[33:32]));
          chk("rdata", mem_rdata, e[31:0]);
        end
        chk("mstdn_low", 32'(mstdn_o), 32'd0);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [1:0] exp_st,
                        output int lat, output int dclk);
    int addr_cyc;
    bit done;
    @(negedge nub_clkn);
    mem_valid = 1'b1; mem_write = wr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    if (!wr && exp_st != 2'b10) model_rdata = rd_val;
    exp_q.push_back({exp_st, model_rdata});
    rq_falls = 0;
    lat = 0; addr_cyc = -1; dclk = -1; done = 1'b0;
    while (!done && lat < 2000) begin
      @(negedge nub_clkn);
      lat++;
      if (startn_o == 1'b0) addr_cyc = lat;
      if (mem_ready) begin
        done = 1'b1;
        dclk = lat - addr_cyc - 1;
      end
    end
    mem_valid = 1'b0;
    if (!done) chk("req_completed", 32'd0, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rqstn"},  32'(rqstn_o),  32'd1);
    chk({tag, "_startn"}, 32'(startn_o), 32'd1);
    chk({tag, "_tm1n"},   32'(tm1n_o),   32'd1);
    chk({tag, "_tm0n"},   32'(tm0n_o),   32'd1);
    chk({tag, "_adn"},    adn_o,         32'hFFFF_FFFF);
    chk({tag, "_ad_oe"},  32'(ad_oe),    32'd0);
    chk({tag, "_ctl_oe"}, 32'(ctl_oe),   32'd0);
    chk({tag, "_ready"},  32'(mem_ready), 32'd0);
    chk({tag, "_mstdn"},  32'(mstdn_o),  32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, dclk, wait_n;
    reset = 1'b1;
    mem_valid = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    arb_grant = 1'b1; nub_startn = 1'b1;
    repeat (3) @(negedge nub_clkn);
    chk_idle_outputs("rst");
    chk("rst_rdata",  mem_rdata, 32'h0);
    chk("rst_status", 32'(mem_status), 32'd0);
    reset = 1'b0;
    @(negedge nub_clkn);

    // word read, ACK on first data clock
    ack_delay = 0; ack_st = 2'b00; rd_val = 32'hCAFE_BABE;
    do_req(1'b0, 32'hF000_1004, 32'h0, 4'b0000, 2'b00, lat, dclk);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_addr", cap_addr, ~32'hF000_1004);
    chk("rd_tm1n", 32'(cap_tm1n), 32'd1);
    chk("rd_tm0n", 32'(cap_tm0n), 32'd1);
    chk("rd_ctl_oe", 32'(cap_ctl), 32'd1);
    chk("rd_data_ad_oe", 32'(cap_data_oe), 32'd0);
    chk("rd_rq_falls", 32'(rq_falls), 32'd1);
    chk("rd_dclk", 32'(dclk), 32'd1);

    // byte write lane 2
    do_req(1'b1, 32'hF000_2000, 32'h1234_5678, 4'b0100, 2'b00, lat, dclk);
    chk("bw_tm1n", 32'(cap_tm1n), 32'd0);
    chk("bw_tm0n", 32'(cap_tm0n), 32'd0);
    chk("bw_addr", cap_addr, ~32'hF000_2002);
    chk("bw_data", cap_data, ~32'h1234_5678);
    chk("bw_data_oe", 32'(cap_data_oe), 32'd1);
    chk("bw_data_ctl", 32'(cap_data_ctl), 32'd0);

    // upper halfword write
    do_req(1'b1, 32'hF000_3000, 32'hBEEF_0000, 4'b1100, 2'b00, lat, dclk);
    chk("hw_addr", cap_addr, ~32'hF000_3003);
    chk("hw_tm0n", 32'(cap_tm0n), 32'd1);

    // try-again four times: retries exhausted
    ta_left = 4; rd_val = 32'h1111_2222;
    do_req(1'b0, 32'hF000_4000, 32'h0, 4'b0000, 2'b11, lat, dclk);
    chk("ta4_rq_falls", 32'(rq_falls), 32'd4);

    // try-again twice then ok
    ta_left = 2; rd_val = 32'h3333_4444;
    do_req(1'b0, 32'hF000_5008, 32'h0, 4'b0000, 2'b00, lat, dclk);
    chk("ta2_rq_falls", 32'(rq_falls), 32'd3);

    // no ACK: timeout after 255 data clocks, bus released
    ta_left = 0; ack_delay = -1;
    do_req(1'b1, 32'hF000_6000, 32'hDEAD_0001, 4'b1111, 2'b10, lat, dclk);
    chk("to_dclk", 32'(dclk), 32'd255);
    chk("to_rqstn", 32'(rqstn_o), 32'd1);
    chk("to_ad_oe", 32'(ad_oe), 32'd0);
    chk("to_ctl_oe", 32'(ctl_oe), 32'd0);

    // ACK on the terminal-count clock wins; slave reports error
    ack_delay = 254; ack_st = 2'b01; rd_val = 32'h5555_AAAA;
    do_req(1'b0, 32'hF000_7000, 32'h0, 4'b0000, 2'b01, lat, dclk);
    chk("ackto_dclk", 32'(dclk), 32'd255);

    // illegal strobe: no bus activity
    ack_delay = 0; ack_st = 2'b00;
    do_req(1'b1, 32'hF000_8000, 32'h0, 4'b0101, 2'b01, lat, dclk);
    chk("bad_latency", 32'(lat), 32'd2);
    chk("bad_rq_falls", 32'(rq_falls), 32'd0);

    // arbitration wait with another master's START seen meanwhile
    arb_grant = 1'b0; rd_val = 32'h0BAD_F00D;
    fork
      do_req(1'b0, 32'hF000_9000, 32'h0, 4'b0000, 2'b00, lat, dclk);
      begin
        repeat (3) @(negedge nub_clkn);
        nub_startn = 1'b0;
        repeat (2) @(negedge nub_clkn);
        nub_startn = 1'b1;
        repeat (2) @(negedge nub_clkn);
        arb_grant = 1'b1;
      end
    join
    chk("arb_latency", 32'(lat), 32'd9);
    chk("arb_rq_falls", 32'(rq_falls), 32'd1);

    // reset in the data phase of a write
    ack_delay = -1;
    @(negedge nub_clkn);
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 32'hF000_A000;
    mem_wdata = 32'h7777_8888; mem_wstrb = 4'b1111;
    wait_n = 0;
    while (startn_o !== 1'b0 && wait_n < 20) begin
      @(negedge nub_clkn);
      wait_n++;
    end
    chk("rs_addr_seen", 32'(startn_o), 32'd0);
    @(negedge nub_clkn);
    chk("rs_pre_ad_oe", 32'(ad_oe), 32'd1);
    reset = 1'b1;
    #1;
    chk_idle_outputs("rs");
    chk("rs_rdata", mem_rdata, 32'h0);
    chk("rs_status", 32'(mem_status), 32'd0);
    @(negedge nub_clkn);
    mem_valid = 1'b0;
    reset = 1'b0;
    model_rdata = 32'h0;

    ack_delay = 0; ack_st = 2'b00; rd_val = 32'hA5A5_5A5A;
    do_req(1'b0, 32'hF000_B00C, 32'h0, 4'b0000, 2'b00, lat, dclk);
    chk("post_rst_latency", 32'(lat), 32'd4);

    repeat (3) @(negedge nub_clkn);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nubus_master.md
# nubus_master

NuBus master (initiator) controller: the requesting end of the same bus protocol the card's slave controller answers. It accepts single-beat read/write requests on the card-local memory-style interface, requests the bus, runs one NuBus address/data transaction, and returns read data and completion status. It sits between the card-local CPU/DMA port and the NuBus pad drivers; arbitration-ID contention is resolved by an external arbiter that returns `arb_grant`.

## Interface
- `TIMEOUT`, 255: data-phase clocks without ACK before local abort (8-bit counter).
- `MAX_RETRY`, 3: try-again re-issues before reporting status 11.
- `nub_clkn` in 1: NuBus clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: local request; held until `mem_ready`.
- `mem_write` in 1: 1 write, 0 read.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: write byte lanes (ignored for reads).
- `mem_ready` out 1: one-clock completion pulse.
- `mem_rdata` out 32: read data, valid with `mem_ready`.
- `mem_status` out 2: 00 ok, 01 error, 10 timeout, 11 try-again exhausted; valid with `mem_ready`.
- `arb_grant` in 1: external arbiter has won the bus for this card.
- `nub_startn` in 1, `nub_ackn` in 1, `nub_tm1n` in 1, `nub_tm0n` in 1, `nub_adn` in 32: sampled bus (active-low, AD inverted).
- `rqstn_o` out 1: bus request, active-low.
- `startn_o`, `tm1n_o`, `tm0n_o` out 1 each; `adn_o` out 32; `ad_oe` out 1 (drive AD); `ctl_oe` out 1 (drive START/TM).
- `mstdn_o` out 1: master done, active-low, low for one clock with `mem_ready`.

## Operation
- States: IDLE, ARB, ADDR, DATA, DONE.
- IDLE: on `mem_valid`, latch addr/data/strb/write, retry count=0, go ARB. Bad strobe (write with pattern not listed below) -> DONE with status 01, no bus activity.
- ARB: `rqstn_o`=0. Go ADDR when `arb_grant` & `nub_startn`=1 & `nub_ackn`=1 (bus idle).
- ADDR (one clock): `startn_o`=0, `ctl_oe`=1, `ad_oe`=1, `adn_o`=~{addr[31:2], a10}; `tm1n_o`=~write's inverse: 1 read, 0 write; `tm0n_o` per size. Release `rqstn_o`. Go DATA.
- Size encoding: word (read, or strb 1111): tm0n=1, a10=00; halfword 0011/1100: tm0n=1, a10=01/11; byte 0001/0010/0100/1000: tm0n=0, a10=lane 0/1/2/3.
- DATA: `startn_o`=1, `ctl_oe`=0; write: `ad_oe`=1, `adn_o`=~wdata; read: `ad_oe`=0. Timeout counter increments each clock.
- ACK (`nub_ackn`=0) in DATA: status={~nub_tm1n,~nub_tm0n}; read latches `mem_rdata`=~`nub_adn`. Status 11 and retry<MAX_RETRY: retry++, go ARB. Otherwise go DONE.
- Counter reaches TIMEOUT with no ACK: status 10, go DONE.
- DONE (one clock): `mem_ready`=1, `mstdn_o`=0, all bus outputs released; go IDLE.
- `nub_startn` low while in ARB without grant (another master started): remain ARB.

## Timing
- Reset values: `rqstn_o`,`startn_o`,`tm1n_o`,`tm0n_o`,`mstdn_o`=1; `adn_o`=all 1; `ad_oe`,`ctl_oe`,`mem_ready`=0; `mem_rdata`=0; `mem_status`=00; state IDLE, counters 0.
- Minimum latency, `mem_valid` to `mem_ready`, grant already asserted and ACK in first data clock: IDLE→ARB→ADDR→DATA→DONE = `mem_ready` 4 clocks after `mem_valid` sampled.
- ACK and timeout terminal count in the same clock: ACK wins.
- `mem_valid` deasserted mid-transaction: ignored; transaction completes.
- Reset mid-transaction: all outputs to reset values asynchronously; no `mem_ready`.
- Only one transaction outstanding; `mem_valid` sampled again in IDLE only.

## Test plan
- Word read 0xF000_1004, grant high, slave ACK TM=ok with `nub_adn`=~0xCAFEBABE on first data clock -> `mem_rdata`=0xCAFEBABE, status 00, `mem_ready` 4 clocks after request, `adn_o`=~0xF000_1004 in ADDR.
- Byte write strb 0100 addr 0xF000_2000 -> ADDR: `tm1n_o`=0, `tm0n_o`=0, `adn_o`=~0xF000_2002; DATA drives ~wdata; ACK ok -> status 00.
- Slave returns try-again 4 times -> 3 re-arbitrations (`rqstn_o` low 4 times total), then status 11.
- No ACK -> `mem_ready` with status 10 exactly TIMEOUT data clocks after ADDR; bus released.
- Write strb 0101 -> status 01, `rqstn_o` never asserts, `mem_ready` 2 clocks after request.
- `reset` pulsed while in DATA -> all outputs at reset values same clock, next request completes normally.
